// File: rtl/scan_delay_timer_gen.sv
// Programmable wait-cycle timer: waits mantissa * 10^exponent clk cycles after start, then pulses done.
// Supports abort, exponent clamping and an optional operator step before completion.
module scan_delay_timer_gen #(
  parameter int MANT_WIDTH     = 4,
  parameter int EXP_WIDTH      = 4,
  parameter int MAX_EXP        = 7,
  parameter int PRESCALE_WIDTH = 26,
  parameter int SIM_FAST       = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [MANT_WIDTH+EXP_WIDTH-1:0] delay,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            step_mode_tck,
  input  logic                            go_step_tck,
  output logic                            done,
  output logic                            aborted,
  output logic                            busy,
  output logic                            exp_clamped,
  output logic [1:0]                      timer_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_COUNT     = 2'd2,
    S_WAIT_STEP = 2'd3
  } state_e;

  localparam int unsigned           MAX_EXP_U = MAX_EXP;
  localparam logic [EXP_WIDTH-1:0]  MAX_EXP_L = EXP_WIDTH'(MAX_EXP);

  state_e                    state_q, state_d;
  logic [MANT_WIDTH-1:0]     mant_q, mant_d;
  logic [EXP_WIDTH-1:0]      exp_q, exp_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [MANT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      aborted_q, aborted_d;
  logic                      clamp_q, clamp_d;

  logic [MANT_WIDTH-1:0]     mant_in;
  logic [EXP_WIDTH-1:0]      exp_in;
  logic                      expire;

  assign mant_in = delay[MANT_WIDTH+EXP_WIDTH-1:EXP_WIDTH];
  assign exp_in  = delay[EXP_WIDTH-1:0];

  function automatic logic [PRESCALE_WIDTH-1:0] pow10_m1(input logic [EXP_WIDTH-1:0] e);
    logic [PRESCALE_WIDTH-1:0] p;
    p        = PRESCALE_WIDTH'(1);
    pow10_m1 = '0;
    for (int unsigned i = 0; i <= MAX_EXP_U; i++) begin
      if (e == EXP_WIDTH'(i)) pow10_m1 = p - PRESCALE_WIDTH'(1);
      p = p * PRESCALE_WIDTH'(10);
    end
  endfunction

  // Expire on the edge where the last prescale period ends, giving exactly D COUNT cycles.
  assign expire = (cnt_q == '0) ||
                  ((cnt_q == MANT_WIDTH'(1)) && (pre_q == '0));

  always_comb begin
    state_d   = state_q;
    mant_d    = mant_q;
    exp_d     = exp_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    clamp_d   = clamp_q;
    if (abort) begin
      clamp_d = 1'b0;
      if (state_q != S_IDLE) begin
        state_d   = S_IDLE;
        aborted_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mant_d  = mant_in;
            exp_d   = (SIM_FAST != 0) ? '0 : ((exp_in > MAX_EXP_L) ? MAX_EXP_L : exp_in);
            clamp_d = (exp_in > MAX_EXP_L) && (SIM_FAST == 0);
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          pre_d   = pow10_m1(exp_q);
          cnt_d   = mant_q;
          state_d = S_COUNT;
        end
        S_COUNT: begin
          if (expire) begin
            if (step_mode_tck) begin
              state_d = S_WAIT_STEP;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else if (pre_q == '0) begin
            pre_d = pow10_m1(exp_q);
            cnt_d = cnt_q - MANT_WIDTH'(1);
          end else begin
            pre_d = pre_q - PRESCALE_WIDTH'(1);
          end
        end
        S_WAIT_STEP: begin
          if (go_step_tck) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mant_q    <= '0;
      exp_q     <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      clamp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mant_q    <= mant_d;
      exp_q     <= exp_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      clamp_q   <= clamp_d;
    end
  end

  assign done        = done_q;
  assign aborted     = aborted_q;
  assign busy        = (state_q != S_IDLE);
  assign exp_clamped = clamp_q;
  assign timer_state = state_q;

endmodule
